// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing one VGA pixel-write port; optional off-screen drop via VGA_ARB_CLIP_EN.
// Plot strobe two edges after the IDLE sample, then PLOT_GAP idle cycles; requesters wait (hold req) until ack.
module vga_plot_arbiter #(
   parameter int NREQ     = 4,
   parameter int PLOT_GAP = 2
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [8*NREQ-1:0] req_x,
   input  logic [7*NREQ-1:0] req_y,
   input  logic [3*NREQ-1:0] req_color,
   output logic [NREQ-1:0]   ack,
   output logic [7:0]        VGA_X,
   output logic [6:0]        VGA_Y,
   output logic [2:0]        VGA_COLOR,
   output logic              plot,
   output logic              busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;

   state_t          state;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   gnt;
   logic [7:0]      gap_cnt;
   logic            drop;

   logic            win_vld;
   logic [IW-1:0]   win;
   logic [7:0]      win_x;
   logic [6:0]      win_y;
   logic [2:0]      win_color;
   logic            win_off;

   // First requester at or after ptr, wrapping modulo NREQ.
   always_comb begin
      int j;
      j         = 0;
      win_vld   = 1'b0;
      win       = '0;
      win_x     = '0;
      win_y     = '0;
      win_color = '0;
      for (int i = 0; i < NREQ; i++) begin
         j = int'(ptr) + i;
         if (j >= NREQ) j = j - NREQ;
         if (!win_vld && req[j]) begin
            win_vld   = 1'b1;
            win       = IW'(j);
            win_x     = req_x[8*j +: 8];
            win_y     = req_y[7*j +: 7];
            win_color = req_color[3*j +: 3];
         end
      end
   end

`ifdef VGA_ARB_CLIP_EN
   assign win_off = (win_x > 8'd159) || (win_y > 7'd119);
`else
   assign win_off = 1'b0;
`endif

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= '0;
         gnt       <= '0;
         gap_cnt   <= '0;
         drop      <= 1'b0;
         VGA_X     <= '0;
         VGA_Y     <= '0;
         VGA_COLOR <= '0;
         plot      <= 1'b0;
         ack       <= '0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (win_vld) begin
                  gnt       <= win;
                  VGA_X     <= win_x;
                  VGA_Y     <= win_y;
                  VGA_COLOR <= win_color;
                  drop      <= win_off;
                  busy      <= 1'b1;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               // Dropped pixels are still acked so the requester can move on.
               plot  <= ~drop;
               ack   <= NREQ'(1) << gnt;
               state <= STROBE;
            end
            STROBE: begin
               plot <= 1'b0;
               ack  <= '0;
               ptr  <= (gnt == IW'(NREQ-1)) ? '0 : gnt + 1'b1;
               if (PLOT_GAP > 0) begin
                  gap_cnt <= 8'(PLOT_GAP - 1);
                  state   <= GAP;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            GAP: begin
               if (gap_cnt == 8'd0) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: two instances (gap 2 and gap 0) against a timeline model.
module tb_vga_plot_arbiter;

   localparam int NREQ = 4;
   localparam int GAP0 = 2;
   localparam int GAP1 = 0;
`ifdef VGA_ARB_CLIP_EN
   localparam bit CLIP = 1'b1;
`else
   localparam bit CLIP = 1'b0;
`endif

   localparam logic [31:0] DX = {8'd33, 8'd32, 8'd31, 8'd30};
   localparam logic [27:0] DY = {7'd53, 7'd52, 7'd51, 7'd50};
   localparam logic [11:0] DC = {3'd7, 3'd6, 3'd5, 3'd4};

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] req_x = '0;
   logic [27:0] req_y = '0;
   logic [11:0] req_color = '0;

   logic [3:0]  ack_s  [2];
   logic [7:0]  vx_s   [2];
   logic [6:0]  vy_s   [2];
   logic [2:0]  vc_s   [2];
   logic        plot_s [2];
   logic        busy_s [2];

   vga_plot_arbiter #(.NREQ(NREQ), .PLOT_GAP(GAP0)) dut0 (
      .CLOCK_50(clk), .reset(rst), .req(req), .req_x(req_x), .req_y(req_y),
      .req_color(req_color), .ack(ack_s[0]), .VGA_X(vx_s[0]), .VGA_Y(vy_s[0]),
      .VGA_COLOR(vc_s[0]), .plot(plot_s[0]), .busy(busy_s[0]));

   vga_plot_arbiter #(.NREQ(NREQ), .PLOT_GAP(GAP1)) dut1 (
      .CLOCK_50(clk), .reset(rst), .req(req), .req_x(req_x), .req_y(req_y),
      .req_color(req_color), .ack(ack_s[1]), .VGA_X(vx_s[1]), .VGA_Y(vy_s[1]),
      .VGA_COLOR(vc_s[1]), .plot(plot_s[1]), .busy(busy_s[1]));

   always #10 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model: each grant is a time stamp; everything else follows by arithmetic.
   int         m_free  [2];
   int         m_grant [2];
   int         m_g     [2];
   int         m_ptr   [2];
   logic [7:0] m_x     [2];
   logic [6:0] m_y     [2];
   logic [2:0] m_c     [2];
   bit         m_on    [2];

   function automatic int gap_of(input int d);
      return (d == 0) ? GAP0 : GAP1;
   endfunction

   task automatic chk(input string nm, input int d, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s dut%0d cyc=%0d got=%0d want=%0d", nm, d, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_free[d]  = 0;
         m_grant[d] = -1000;
         m_g[d]     = 0;
         m_ptr[d]   = 0;
         m_x[d]     = '0;
         m_y[d]     = '0;
         m_c[d]     = '0;
         m_on[d]    = 1'b0;
      end
   endtask

   task automatic model_edge();
      int g;
      cyc++;
      if (rst) return;
      for (int d = 0; d < 2; d++) begin
         if (cyc >= m_free[d] && req != 4'd0) begin
            g = -1;
            for (int i = 0; i < NREQ; i++)
               if (g < 0 && req[(m_ptr[d] + i) % NREQ]) g = (m_ptr[d] + i) % NREQ;
            m_g[d]     = g;
            m_grant[d] = cyc;
            m_free[d]  = cyc + 3 + gap_of(d);
            m_ptr[d]   = (g + 1) % NREQ;
            m_x[d]     = req_x[8*g +: 8];
            m_y[d]     = req_y[7*g +: 7];
            m_c[d]     = req_color[3*g +: 3];
            m_on[d]    = !CLIP || (m_x[d] <= 8'd159 && m_y[d] <= 7'd119);
         end
      end
   endtask

   task automatic check_all();
      bit s;
      for (int d = 0; d < 2; d++) begin
         s = (cyc == m_grant[d] + 1);
         chk("ack", d, int'(ack_s[d]), s ? (1 << m_g[d]) : 0);
         chk("plot", d, int'(plot_s[d]), int'(s && m_on[d]));
         chk("busy", d, int'(busy_s[d]),
             int'(cyc >= m_grant[d] && cyc <= m_grant[d] + 1 + gap_of(d)));
         chk("vga_x", d, int'(vx_s[d]), int'(m_x[d]));
         chk("vga_y", d, int'(vy_s[d]), int'(m_y[d]));
         chk("vga_color", d, int'(vc_s[d]), int'(m_c[d]));
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      #1;
      check_all();
      step();
      rst = 1'b0;
   endtask

   task automatic wait_ack(input int d, output int idx, output int t);
      idx = -1;
      t   = 0;
      for (int k = 0; k < 60; k++) begin
         step();
         if (ack_s[d] != 4'd0) begin
            for (int b = 0; b < 4; b++) if (ack_s[d][b]) idx = b;
            t = cyc;
            break;
         end
      end
      if (idx < 0) begin
         total++;
         bad++;
         $display("FAIL ack_timeout dut%0d cyc=%0d got=none want=ack", d, cyc);
      end
   endtask

   task automatic wait_idle0();
      for (int k = 0; k < 40; k++) begin
         if (!busy_s[0]) break;
         step();
      end
      if (busy_s[0]) begin
         total++;
         bad++;
         $display("FAIL idle_timeout dut0 cyc=%0d got=busy want=idle", cyc);
      end
   endtask

   typedef struct {
      logic [3:0]  rq;
      logic [31:0] xs;
      logic [27:0] ys;
      logic [11:0] cs;
      int          eg;
      logic [7:0]  ex;
      logic [6:0]  ey;
      logic [2:0]  ec;
      bit          ep;
   } vec_t;

   vec_t vt [10];

   initial begin
      int idx, t, prev, n, np, last, low;
      bit got;

      // Expected grants follow dut0's pointer from reset (0) across the list.
      vt[0] = '{4'b0001, {8'd33, 8'd32, 8'd31, 8'd10}, {7'd53, 7'd52, 7'd51, 7'd20},
                {3'd7, 3'd6, 3'd5, 3'd3}, 0, 8'd10, 7'd20, 3'd3, 1'b1};
      vt[1] = '{4'b1111, DX, DY, DC, 1, 8'd31, 7'd51, 3'd5, 1'b1};
      vt[2] = '{4'b0011, DX, DY, DC, 0, 8'd30, 7'd50, 3'd4, 1'b1};
      vt[3] = '{4'b0011, DX, DY, DC, 1, 8'd31, 7'd51, 3'd5, 1'b1};
      vt[4] = '{4'b1000, {8'd200, 8'd32, 8'd31, 8'd30}, {7'd5, 7'd52, 7'd51, 7'd50},
                DC, 3, 8'd200, 7'd5, 3'd7, !CLIP};
      vt[5] = '{4'b0110, DX, DY, DC, 1, 8'd31, 7'd51, 3'd5, 1'b1};
      vt[6] = '{4'b1100, DX, DY, DC, 2, 8'd32, 7'd52, 3'd6, 1'b1};
      vt[7] = '{4'b0101, DX, DY, DC, 0, 8'd30, 7'd50, 3'd4, 1'b1};
      vt[8] = '{4'b0100, {8'd33, 8'd159, 8'd31, 8'd30}, {7'd53, 7'd119, 7'd51, 7'd50},
                DC, 2, 8'd159, 7'd119, 3'd6, 1'b1};
      vt[9] = '{4'b0100, {8'd33, 8'd0, 8'd31, 8'd30}, {7'd53, 7'd120, 7'd51, 7'd50},
                DC, 2, 8'd0, 7'd120, 3'd6, !CLIP};

      #2;
      do_reset();

      for (int v = 0; v < 10; v++) begin
         wait_idle0();
         req_x     = vt[v].xs;
         req_y     = vt[v].ys;
         req_color = vt[v].cs;
         req       = vt[v].rq;
         n   = 0;
         got = 1'b0;
         for (int k = 0; k < 10; k++) begin
            step();
            n++;
            if (ack_s[0] != 4'd0) begin
               got = 1'b1;
               break;
            end
         end
         if (!got) begin
            total++;
            bad++;
            $display("FAIL tbl_timeout vec=%0d got=none want=ack", v);
         end else begin
            chk("tbl_latency", 0, n, 2);
            chk("tbl_ack", 0, int'(ack_s[0]), 1 << vt[v].eg);
            chk("tbl_x", 0, int'(vx_s[0]), int'(vt[v].ex));
            chk("tbl_y", 0, int'(vy_s[0]), int'(vt[v].ey));
            chk("tbl_color", 0, int'(vc_s[0]), int'(vt[v].ec));
            chk("tbl_plot", 0, int'(plot_s[0]), int'(vt[v].ep));
         end
         req = 4'd0;
      end

      // All requesters held: strict rotation, strobes 3+GAP0 apart.
      do_reset();
      req_x = DX; req_y = DY; req_color = DC;
      req  = 4'b1111;
      prev = 0;
      for (int i = 0; i < 8; i++) begin
         wait_ack(0, idx, t);
         chk("rr_order", 0, idx, i % 4);
         if (i > 0) chk("rr_spacing", 0, t - prev, 3 + GAP0);
         prev = t;
      end
      req = 4'd0;

      // Pointer at 2, then a late request from requester 2.
      do_reset();
      req = 4'b0010;
      wait_ack(0, idx, t);
      chk("ptr_setup", 0, idx, 1);
      req = 4'b0011;
      wait_ack(0, idx, t);
      chk("ptr_wrap", 0, idx, 0);
      step();
      req = 4'b0111;
      wait_ack(0, idx, t);
      chk("ptr_next", 0, idx, 1);
      wait_ack(0, idx, t);
      chk("ptr_late", 0, idx, 2);
      req = 4'd0;

      // Zero gap: plot every 3 cycles, busy low for one.
      do_reset();
      req  = 4'b0010;
      np   = 0;
      last = 0;
      low  = 0;
      for (int k = 0; k < 40 && np < 4; k++) begin
         step();
         if (plot_s[1]) begin
            if (np > 0) begin
               chk("gap0_spacing", 1, cyc - last, 3);
               chk("gap0_idle", 1, low, 1);
            end
            last = cyc;
            low  = 0;
            np++;
         end else if (!busy_s[1]) begin
            low++;
         end
      end
      if (np < 4) begin
         total++;
         bad++;
         $display("FAIL gap0_timeout dut1 got=%0d want=4 plots", np);
      end
      req = 4'd0;

      // Reset landing in STROBE aborts and restarts from requester 0.
      do_reset();
      req = 4'b0001;
      got = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (plot_s[0]) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL strobe_timeout dut0 got=none want=plot");
      end
      rst = 1'b1;
      model_reset();
      #1;
      chk("rst_plot", 0, int'(plot_s[0]), 0);
      chk("rst_ack", 0, int'(ack_s[0]), 0);
      chk("rst_busy", 0, int'(busy_s[0]), 0);
      chk("rst_x", 0, int'(vx_s[0]), 0);
      step();
      rst = 1'b0;
      req = 4'b1001;
      wait_ack(0, idx, t);
      chk("post_rst_grant", 0, idx, 0);
      req = 4'd0;

      // Random traffic with occasional asynchronous resets.
      for (int k = 0; k < 1500; k++) begin
         req       = 4'($urandom) & 4'($urandom);
         req_x     = $urandom;
         req_y     = 28'($urandom);
         req_color = 12'($urandom);
         if ($urandom_range(0, 99) == 0) begin
            rst = 1'b1;
            model_reset();
            #1;
            check_all();
         end
         step();
         rst = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_plot_arbiter.md
# vga_plot_arbiter

Shares the single simulated VGA pixel-write port (VGA_X, VGA_Y, VGA_COLOR, plot) among NREQ independent drawing engines. Each requester presents a coordinate/colour and holds a request; the arbiter grants round-robin, sequences a setup cycle and a one-cycle plot strobe, acknowledges the winner, then enforces a programmable idle gap before the next plot. It sits between the user drawing logic and the top-level VGA ports that DESim's `$sim_fpga` samples.

## Interface
- NREQ, 4: number of requesters (2..8).
- PLOT_GAP, 2: idle cycles after each strobe before the next arbitration (0..255).
- CLOCK_50  in  1: 50 MHz clock, all logic on rising edge.
- reset  in  1: asynchronous, active-high reset.
- req  in  NREQ: level request per requester.
- req_x  in  8*NREQ: column of requester i at [8i+7:8i].
- req_y  in  7*NREQ: row of requester i at [7i+6:7i].
- req_color  in  3*NREQ: colour of requester i at [3i+2:3i].
- ack  out  NREQ: one-cycle pulse; requester i's pixel has been strobed.
- VGA_X  out  8: registered column.
- VGA_Y  out  7: registered row.
- VGA_COLOR  out  3: registered colour.
- plot  out  1: one-cycle pixel write strobe.
- busy  out  1: high whenever state is not IDLE.

## Operation
- States: IDLE, SETUP, STROBE, GAP.
- IDLE: if any req bit set, select winner g = first set bit scanning ptr, ptr+1, ... mod NREQ; latch winner's x/y/color into VGA_X/Y/COLOR; go SETUP. No request: stay, outputs hold last values.
- SETUP: plot=0, outputs stable; go STROBE.
- STROBE: plot=1 and ack[g]=1 for exactly this cycle; ptr <= (g+1) mod NREQ; go GAP if PLOT_GAP>0, else IDLE.
- GAP: counter loads PLOT_GAP-1 on entry, decrements each cycle; go IDLE when counter is 0.
- Requester contract: hold req and data stable from assertion through ack; data is sampled only at the IDLE->SETUP edge. req still high at the next IDLE is a new request (duplicate plot).
- Changes to req of the current winner after latch are ignored; its ack still fires.
- Only one ack bit ever high; ack never high outside STROBE.
- Round-robin fairness: with all requesters permanently active, grants cycle 0,1,...,NREQ-1 strictly.

## Timing
- Reset (asynchronous assert): state IDLE, ptr 0, gap counter 0, VGA_X 0, VGA_Y 0, VGA_COLOR 0, plot 0, ack 0, busy 0. Reset mid-SETUP/STROBE/GAP aborts; no ack issued for the aborted grant.
- Request sampled at edge k in IDLE: outputs valid after edge k, plot and ack high between edges k+1 and k+2.
- Throughput: one plot per 3+PLOT_GAP cycles under continuous requests.
- busy rises after edge k, falls after the last GAP (or STROBE) cycle.

## Configuration
- VGA_ARB_CLIP_EN defined: in IDLE a winner with x>159 or y>119 is still latched, sequenced and acked, but plot stays 0 in STROBE (off-screen pixel dropped, 160x120 frame).
- Undefined: no range check; every grant strobes plot.

## Test plan
- Reset, then single req[0] with x=10, y=20, color=3 -> plot high exactly one cycle two edges later with VGA_X=10, VGA_Y=20, VGA_COLOR=3; ack[0] coincident.
- req=4'b1111 held for 8 grants, PLOT_GAP=2 -> ack order 0,1,2,3,0,1,2,3; strobes exactly 5 cycles apart.
- ptr=2 state, req=4'b0011 -> grant 0 then 1; req[2] raised during GAP -> granted after 1 (scan from ptr).
- PLOT_GAP=0, req[1] held continuously -> plot every 3 cycles, busy low one cycle between grants.
- With VGA_ARB_CLIP_EN: req[3] x=200, y=5 -> ack[3] pulses, plot stays 0; without macro -> plot pulses with VGA_X=200.
- Assert reset during STROBE -> plot and ack drop immediately, outputs 0, no ack; next req granted normally starting from requester 0.
